// File: rtl/search_super_node_control.sv
// Sequencer for the super-node search datapath.
// Runs one reference-node / voltage-source DFS pass per accepted start and reports done/error.
// Every go_* output is a pure decode of the state register. Each go_* is held high for the
// whole state and drops the cycle after that state's ack is sampled. Acks that belong to other
// states are never looked at.
// Watchdog: wdog counts cycles spent in the current busy state and clears on every state change.
module search_super_node_control #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8,
    parameter int MAX_DEPTH = 4,
    localparam int DEPTH_W  = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         error_code,
    output logic [4:0]         super_node_count,
    output logic               go_reset_data,
    output logic               go_to_next_node,
    output logic               go_check_node_status,
    output logic               go_register_reference_node,
    output logic               go_check_element_type,
    output logic               go_store_element_addr,
    output logic               go_update_voltage_difference,
    output logic               begin_search_new_node,
    output logic               go_to_next_element,
    output logic               go_backtrace_dfs,
    output logic               go_backtrace_curr_search_addr,
    input  logic               data_reset_done,
    input  logic               next_node_reached,
    input  logic               node_checked,
    input  logic               node_valid,
    input  logic               loop_done,
    input  logic               reference_node_registered,
    input  logic               type_checked,
    input  logic               is_voltage,
    input  logic               current_element_addr_stored,
    input  logic               voltage_difference_updated,
    input  logic               new_node_search_began,
    input  logic               next_element_reached,
    input  logic               end_of_list_reached,
    input  logic               backtrace_done,
    input  logic               whole_dfs_done,
    input  logic               backtrace_curr_search_addr_done,
    output logic [3:0]         state_dbg,
    output logic [DEPTH_W-1:0] depth_dbg
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        RESET_DATA = 4'd1,
        NEXT_NODE  = 4'd2,
        CHECK_NODE = 4'd3,
        REG_REF    = 4'd4,
        CHECK_TYPE = 4'd5,
        STORE_ADDR = 4'd6,
        UPDATE_V   = 4'd7,
        SWITCH     = 4'd8,
        NEXT_ELEM  = 4'd9,
        BACKTRACE  = 4'd10,
        RESTORE    = 4'd11,
        DONE       = 4'd12,
        ERROR      = 4'd13
    } state_t;

    state_t               state, state_next;
    logic [TIMEOUT_W-1:0] wdog;
    logic [DEPTH_W-1:0]   depth;
    logic [4:0]           count;
    logic [1:0]           code;
    logic                 accept_start, inc_count, inc_depth, dec_depth;
    logic                 set_timeout, set_overflow, timeout_hit, in_wait;

    assign in_wait     = (state != IDLE) && (state != DONE) && (state != ERROR);
    assign timeout_hit = (TIMEOUT != 0) && (wdog == TIMEOUT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode and the datapath side effects of each transition.
    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        inc_count    = 1'b0;
        inc_depth    = 1'b0;
        dec_depth    = 1'b0;
        set_timeout  = 1'b0;
        set_overflow = 1'b0;
        case (state)
            IDLE, ERROR: if (start) begin
                state_next   = RESET_DATA;
                accept_start = 1'b1;
            end
            DONE: begin
                state_next = IDLE;
                if (start) begin
                    state_next   = RESET_DATA;
                    accept_start = 1'b1;
                end
            end
            RESET_DATA: if (data_reset_done)   state_next = NEXT_NODE;
            NEXT_NODE:  if (next_node_reached) state_next = CHECK_NODE;
            CHECK_NODE: if (node_checked) begin
                if (node_valid)     state_next = REG_REF;
                else if (loop_done) state_next = DONE;
                else                state_next = NEXT_NODE;
            end
            REG_REF: if (reference_node_registered) begin
                state_next = CHECK_TYPE;
                inc_count  = 1'b1;
            end
            CHECK_TYPE: if (type_checked) state_next = is_voltage ? STORE_ADDR : NEXT_ELEM;
            STORE_ADDR: if (current_element_addr_stored) state_next = UPDATE_V;
            UPDATE_V: if (voltage_difference_updated) begin
                if (depth == DEPTH_W'(MAX_DEPTH)) begin
                    state_next   = ERROR;
                    set_overflow = 1'b1;
                end else begin
                    state_next = SWITCH;
                    inc_depth  = 1'b1;
                end
            end
            SWITCH: if (new_node_search_began) state_next = CHECK_TYPE;
            NEXT_ELEM: begin
                if (next_element_reached)     state_next = CHECK_TYPE;
                else if (end_of_list_reached) state_next = BACKTRACE;
            end
            BACKTRACE: begin
                if (whole_dfs_done) state_next = loop_done ? DONE : NEXT_NODE;
                else if (backtrace_done) begin
                    state_next = RESTORE;
                    dec_depth  = 1'b1;
                end
            end
            RESTORE: if (backtrace_curr_search_addr_done) state_next = NEXT_ELEM;
            default: state_next = IDLE;
        endcase
        // No wait state ever loops to itself, so "still here" means no ack arrived.
        if (in_wait && (state_next == state) && timeout_hit) begin
            state_next  = ERROR;
            set_timeout = 1'b1;
        end
    end

    // Watchdog, reference-node counter, DFS depth and error code.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog  <= '0;
            depth <= '0;
            count <= '0;
            code  <= 2'b00;
        end else begin
            if (state_next != state || !in_wait) wdog <= '0;
            else                                 wdog <= wdog + 1'b1;
            if (accept_start) begin
                depth <= '0;
                count <= '0;
                code  <= 2'b00;
            end else begin
                if (inc_count && count != 5'd31) count <= count + 5'd1;
                if (inc_depth)                   depth <= depth + 1'b1;
                if (dec_depth && depth != '0)    depth <= depth - 1'b1;
                if (set_timeout)                 code  <= 2'b01;
                if (set_overflow)                code  <= 2'b10;
            end
        end
    end

    // Moore output decode.
    assign busy                          = in_wait;
    assign done                          = (state == DONE);
    assign error                         = (state == ERROR);
    assign error_code                    = code;
    assign super_node_count              = count;
    assign go_reset_data                 = (state == RESET_DATA);
    assign go_to_next_node               = (state == NEXT_NODE);
    assign go_check_node_status          = (state == CHECK_NODE);
    assign go_register_reference_node    = (state == REG_REF);
    assign go_check_element_type         = (state == CHECK_TYPE);
    assign go_store_element_addr         = (state == STORE_ADDR);
    assign go_update_voltage_difference  = (state == UPDATE_V);
    assign begin_search_new_node         = (state == SWITCH);
    assign go_to_next_element            = (state == NEXT_ELEM);
    assign go_backtrace_dfs              = (state == BACKTRACE);
    assign go_backtrace_curr_search_addr = (state == RESTORE);
    assign state_dbg                     = state;
    assign depth_dbg                     = depth;

endmodule

// File: tb/tb_search_super_node_control.sv
// Directed bench for search_super_node_control. The bench plays the datapath: it checks which
// go_* is up, then returns the matching ack for one cycle. Inputs change and outputs are
// sampled on the falling edge.
// Handshake: a go_* stays high while its state waits; one cycle of ack high at the rising edge
// moves the controller on, and the ack is dropped at the following falling edge.
module tb_search_super_node_control;

    localparam logic [3:0] S_IDLE = 4'd0, S_RESET_DATA = 4'd1, S_CHECK_NODE = 4'd3,
                           S_CHECK_TYPE = 4'd5, S_UPDATE_V = 4'd7, S_DONE = 4'd12,
                           S_ERROR = 4'd13;

    localparam int G_RST = 0, G_NN = 1, G_CHK = 2, G_REG = 3, G_TYPE = 4, G_STORE = 5,
                   G_UPD = 6, G_SW = 7, G_NE = 8, G_BT = 9, G_RESTORE = 10;

    localparam logic [15:0] A_RST = 16'h0001, A_NN = 16'h0002, A_CHK = 16'h0004,
                            A_VALID = 16'h0008, A_LOOP = 16'h0010, A_REG = 16'h0020,
                            A_TYPE = 16'h0040, A_VOLT = 16'h0080, A_STORE = 16'h0100,
                            A_UPD = 16'h0200, A_SW = 16'h0400, A_NE = 16'h0800,
                            A_EOL = 16'h1000, A_BT = 16'h2000, A_WHOLE = 16'h4000,
                            A_RESTORE = 16'h8000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] ack_in = '0;
    logic        busy, done, error;
    logic [1:0]  error_code;
    logic [4:0]  super_node_count;
    logic [10:0] go_vec;
    logic [3:0]  state_dbg;
    logic [2:0]  depth_dbg;
    int          n_checks = 0;
    int          n_errors = 0;

    search_super_node_control #(.TIMEOUT(16), .TIMEOUT_W(8), .MAX_DEPTH(4)) dut (
        .clk                             (clk),
        .reset                           (reset),
        .start                           (start),
        .busy                            (busy),
        .done                            (done),
        .error                           (error),
        .error_code                      (error_code),
        .super_node_count                (super_node_count),
        .go_reset_data                   (go_vec[0]),
        .go_to_next_node                 (go_vec[1]),
        .go_check_node_status            (go_vec[2]),
        .go_register_reference_node      (go_vec[3]),
        .go_check_element_type           (go_vec[4]),
        .go_store_element_addr           (go_vec[5]),
        .go_update_voltage_difference    (go_vec[6]),
        .begin_search_new_node           (go_vec[7]),
        .go_to_next_element              (go_vec[8]),
        .go_backtrace_dfs                (go_vec[9]),
        .go_backtrace_curr_search_addr   (go_vec[10]),
        .data_reset_done                 (ack_in[0]),
        .next_node_reached               (ack_in[1]),
        .node_checked                    (ack_in[2]),
        .node_valid                      (ack_in[3]),
        .loop_done                       (ack_in[4]),
        .reference_node_registered       (ack_in[5]),
        .type_checked                    (ack_in[6]),
        .is_voltage                      (ack_in[7]),
        .current_element_addr_stored     (ack_in[8]),
        .voltage_difference_updated      (ack_in[9]),
        .new_node_search_began           (ack_in[10]),
        .next_element_reached            (ack_in[11]),
        .end_of_list_reached             (ack_in[12]),
        .backtrace_done                  (ack_in[13]),
        .whole_dfs_done                  (ack_in[14]),
        .backtrace_curr_search_addr_done (ack_in[15]),
        .state_dbg                       (state_dbg),
        .depth_dbg                       (depth_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expect exactly one go_* up, then answer it with ack bits for one cycle.
    task automatic hs(input string tag, input int go_idx, input logic [15:0] bits);
        check_eq(tag, 32'(go_vec), 32'd1 << go_idx);
        ack_in = bits;
        @(negedge clk);
        ack_in = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_accept", 32'(state_dbg), 32'(S_RESET_DATA));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Two valid nodes, no voltage sources; a third node check is invalid with loop_done.
    task automatic two_node_pass(input bit hold);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        check_eq("p_state_rst", 32'(state_dbg), 32'(S_RESET_DATA));
        check_eq("p_busy", 32'(busy), 32'd1);
        check_eq("p_count0", 32'(super_node_count), 32'd0);
        hs("p_rst", G_RST, A_RST | A_VALID);
        hs("p_nn1", G_NN, A_NN | A_RST);
        hs("p_chk1", G_CHK, A_CHK | A_VALID);
        hs("p_reg1", G_REG, A_REG);
        check_eq("p_count1", 32'(super_node_count), 32'd1);
        hs("p_type1", G_TYPE, A_TYPE);
        hs("p_ne1", G_NE, A_EOL);
        hs("p_bt1", G_BT, A_WHOLE);
        hs("p_nn2", G_NN, A_NN);
        hs("p_chk2", G_CHK, A_CHK | A_VALID);
        hs("p_reg2", G_REG, A_REG);
        hs("p_type2", G_TYPE, A_TYPE);
        hs("p_ne2", G_NE, A_EOL);
        hs("p_bt2", G_BT, A_WHOLE);
        hs("p_nn3", G_NN, A_NN);
        hs("p_chk3", G_CHK, A_CHK | A_LOOP);
        check_eq("p_done", 32'(done), 32'd1);
        check_eq("p_state_done", 32'(state_dbg), 32'(S_DONE));
        check_eq("p_count2", 32'(super_node_count), 32'd2);
        check_eq("p_error", 32'(error), 32'd0);
        check_eq("p_busy_done", 32'(busy), 32'd0);
        check_eq("p_go_done", 32'(go_vec), 32'd0);
        @(negedge clk);
        if (hold) begin
            check_eq("p_restart", 32'(state_dbg), 32'(S_RESET_DATA));
            check_eq("p_restart_busy", 32'(busy), 32'd1);
            check_eq("p_restart_count", 32'(super_node_count), 32'd0);
            start = 1'b0;
        end else begin
            check_eq("p_idle", 32'(state_dbg), 32'(S_IDLE));
            check_eq("p_done_pulse", 32'(done), 32'd0);
        end
    endtask

    initial begin
        // Reset.
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_state", 32'(state_dbg), 32'(S_IDLE));
        check_eq("rst_go", 32'(go_vec), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_code", 32'(error_code), 32'd0);
        check_eq("rst_count", 32'(super_node_count), 32'd0);
        check_eq("rst_depth", 32'(depth_dbg), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_hold", 32'(state_dbg), 32'(S_IDLE));

        // 1: two nodes, no sources.
        two_node_pass(1'b0);

        // 2: one voltage source, plus ack-priority cases.
        pulse_start();
        hs("v_rst", G_RST, A_RST);
        hs("v_nn", G_NN, A_NN);
        hs("v_chk", G_CHK, A_CHK | A_VALID);
        hs("v_reg", G_REG, A_REG);
        hs("v_type", G_TYPE, A_TYPE | A_VOLT);
        hs("v_store", G_STORE, A_STORE);
        hs("v_upd", G_UPD, A_UPD);
        check_eq("v_depth1", 32'(depth_dbg), 32'd1);
        hs("v_sw", G_SW, A_SW);
        hs("v_type2", G_TYPE, A_TYPE);
        hs("v_ne_prio", G_NE, A_NE | A_EOL);
        check_eq("v_ne_prio_state", 32'(state_dbg), 32'(S_CHECK_TYPE));
        hs("v_type3", G_TYPE, A_TYPE);
        hs("v_ne_eol", G_NE, A_EOL);
        hs("v_bt", G_BT, A_BT);
        check_eq("v_depth0", 32'(depth_dbg), 32'd0);
        hs("v_restore", G_RESTORE, A_RESTORE);
        hs("v_ne_eol2", G_NE, A_EOL);
        hs("v_bt_prio", G_BT, A_BT | A_WHOLE | A_LOOP);
        check_eq("v_done", 32'(done), 32'd1);
        check_eq("v_count", 32'(super_node_count), 32'd1);
        check_eq("v_depth_end", 32'(depth_dbg), 32'd0);
        @(negedge clk);

        // 3: five chained sources overflow the DFS stack.
        pulse_start();
        hs("o_rst", G_RST, A_RST);
        hs("o_nn", G_NN, A_NN);
        hs("o_chk", G_CHK, A_CHK | A_VALID);
        hs("o_reg", G_REG, A_REG);
        for (int i = 0; i < 5; i++) begin
            hs("o_type", G_TYPE, A_TYPE | A_VOLT);
            hs("o_store", G_STORE, A_STORE);
            hs("o_upd", G_UPD, A_UPD);
            if (i < 4) begin
                check_eq("o_depth", 32'(depth_dbg), 32'(i + 1));
                hs("o_sw", G_SW, A_SW);
            end
        end
        check_eq("o_state", 32'(state_dbg), 32'(S_ERROR));
        check_eq("o_error", 32'(error), 32'd1);
        check_eq("o_code", 32'(error_code), 32'd2);
        check_eq("o_go", 32'(go_vec), 32'd0);
        check_eq("o_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("o_sticky", 32'(error), 32'd1);

        // 4: node_checked never comes back; restart from ERROR clears the error.
        pulse_start();
        check_eq("w_error_clr", 32'(error), 32'd0);
        check_eq("w_code_clr", 32'(error_code), 32'd0);
        hs("w_rst", G_RST, A_RST);
        hs("w_nn", G_NN, A_NN);
        check_eq("w_in_chk", 32'(state_dbg), 32'(S_CHECK_NODE));
        begin
            int n = 0;
            while (!error && n < 40) begin
                @(negedge clk);
                n++;
            end
            check_eq("w_cycles", 32'(n), 32'd16);
        end
        check_eq("w_code", 32'(error_code), 32'd1);
        check_eq("w_go", 32'(go_vec), 32'd0);

        // 5: reset during UPDATE_V, then a clean pass.
        pulse_start();
        hs("r_rst", G_RST, A_RST);
        hs("r_nn", G_NN, A_NN);
        hs("r_chk", G_CHK, A_CHK | A_VALID);
        hs("r_reg", G_REG, A_REG);
        hs("r_type", G_TYPE, A_TYPE | A_VOLT);
        hs("r_store", G_STORE, A_STORE);
        check_eq("r_in_upd", 32'(state_dbg), 32'(S_UPDATE_V));
        pulse_reset();
        check_eq("r_state", 32'(state_dbg), 32'(S_IDLE));
        check_eq("r_go", 32'(go_vec), 32'd0);
        check_eq("r_count", 32'(super_node_count), 32'd0);
        check_eq("r_busy", 32'(busy), 32'd0);
        two_node_pass(1'b0);

        // 6: start held through a whole pass restarts only from DONE.
        two_node_pass(1'b1);
        pulse_reset();
        check_eq("h_idle", 32'(state_dbg), 32'(S_IDLE));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
